// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Common-data-bus arbiter. FU_COUNT functional units share CDB_PORTS
// broadcast slots. Each FU owns a small circular result FIFO (BUF_DEPTH
// entries). Every cycle the non-empty FIFO heads are scanned round-robin
// starting at the pointer rr, and the first CDB_PORTS of them are granted to
// slots 0..n-1 in scan order. Granted heads pop and load the registered CDB
// outputs. A flush empties every FIFO and cancels the cycle's broadcasts.
//
// Optional feature (macro CDB_ARB_BYPASS_EN):
//   An FU with an empty FIFO that presents a result (no flush) competes in
//   the same cycle. If granted, the result goes straight to the CDB register
//   (latency 1) without touching the FIFO. Otherwise it is pushed normally.
//   Without the macro every result goes through its FIFO (latency >= 2).
//
// Ports:
//   clk            core clock
//   n_rst          asynchronous active-low reset
//   i_flush        pipeline flush (ROB redirect)
//   i_fu_en        per-FU result valid
//   i_fu_redirect  per-FU redirect flag
//   i_fu_data      per-FU result data, FU k in slice k
//   i_fu_addr      per-FU redirect address, FU k in slice k
//   i_fu_tag       per-FU ROB tag, FU k in slice k
//   o_fu_stall     per-FU buffer full (from registered state only)
//   o_cdb_en       per-slot broadcast valid
//   o_cdb_redirect per-slot redirect flag
//   o_cdb_data     per-slot data, slot j in slice j
//   o_cdb_addr     per-slot address, slot j in slice j
//   o_cdb_tag      per-slot tag, slot j in slice j
// ---------------------------------------------------------------------------

// Checker: a result offered to a full FIFO is silently dropped.
module cdb_arbiter_chk #(
  parameter int FU_COUNT = 4
) (
  input logic                clk,
  input logic                n_rst,
  input logic                i_flush,
  input logic [FU_COUNT-1:0] i_fu_en,
  input logic [FU_COUNT-1:0] o_fu_stall
);

  a_no_drop_on_stall: assert property (
    @(posedge clk) disable iff (!n_rst)
    (i_flush || ((i_fu_en & o_fu_stall) == '0))
  ) else $error("cdb_arbiter: result dropped, FU mask %b stalled", i_fu_en & o_fu_stall);

endmodule

module cdb_arbiter #(
  parameter int FU_COUNT   = 4,
  parameter int CDB_PORTS  = 2,
  parameter int BUF_DEPTH  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            i_flush,
  input  logic [FU_COUNT-1:0]             i_fu_en,
  input  logic [FU_COUNT-1:0]             i_fu_redirect,
  input  logic [FU_COUNT*DATA_WIDTH-1:0]  i_fu_data,
  input  logic [FU_COUNT*ADDR_WIDTH-1:0]  i_fu_addr,
  input  logic [FU_COUNT*TAG_WIDTH-1:0]   i_fu_tag,
  output logic [FU_COUNT-1:0]             o_fu_stall,
  output logic [CDB_PORTS-1:0]            o_cdb_en,
  output logic [CDB_PORTS-1:0]            o_cdb_redirect,
  output logic [CDB_PORTS*DATA_WIDTH-1:0] o_cdb_data,
  output logic [CDB_PORTS*ADDR_WIDTH-1:0] o_cdb_addr,
  output logic [CDB_PORTS*TAG_WIDTH-1:0]  o_cdb_tag
);

  // Entry layout: {redirect, addr, data, tag}
  localparam int ENTRY_W  = 1 + ADDR_WIDTH + DATA_WIDTH + TAG_WIDTH;
  localparam int TAG_LSB  = 0;
  localparam int DATA_LSB = TAG_WIDTH;
  localparam int ADDR_LSB = TAG_WIDTH + DATA_WIDTH;
  localparam int RED_BIT  = ENTRY_W - 1;
  localparam int PTR_W    = $clog2(BUF_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int IDX_W    = $clog2(FU_COUNT);
  localparam int SLOT_W   = $clog2(CDB_PORTS + 1);

  // Registered state
  logic [ENTRY_W-1:0]   mem_r    [FU_COUNT][BUF_DEPTH];
  logic [PTR_W-1:0]     rd_ptr_r [FU_COUNT];
  logic [PTR_W-1:0]     wr_ptr_r [FU_COUNT];
  logic [CNT_W-1:0]     count_r  [FU_COUNT];
  logic [FU_COUNT-1:0]  stall_r;
  logic [IDX_W-1:0]     rr_r;

  // Combinational signals
  logic [ENTRY_W-1:0]   in_entry_s   [FU_COUNT];
  logic [ENTRY_W-1:0]   head_s       [FU_COUNT];
  logic [ENTRY_W-1:0]   cand_entry_s [FU_COUNT];
  logic [CNT_W-1:0]     count_nxt_s  [FU_COUNT];
  logic [FU_COUNT-1:0]  empty_s;
  logic [FU_COUNT-1:0]  full_s;
  logic [FU_COUNT-1:0]  bypass_cand_s;
  logic [FU_COUNT-1:0]  cand_s;
  logic [FU_COUNT-1:0]  grant_s;
  logic [FU_COUNT-1:0]  pop_s;
  logic [FU_COUNT-1:0]  push_s;
  logic [IDX_W-1:0]     slot_fu_s    [CDB_PORTS];
  logic [CDB_PORTS-1:0] slot_vld_s;
  logic [ENTRY_W-1:0]   slot_entry_s [CDB_PORTS];
  logic [IDX_W-1:0]     rr_nxt_s;

  assign o_fu_stall = stall_r;

  // Per-FU entry packing, FIFO status and arbitration candidates
  always_comb begin
    for (int k = 0; k < FU_COUNT; k++) begin
      in_entry_s[k] = {i_fu_redirect[k],
                       i_fu_addr[k*ADDR_WIDTH +: ADDR_WIDTH],
                       i_fu_data[k*DATA_WIDTH +: DATA_WIDTH],
                       i_fu_tag[k*TAG_WIDTH +: TAG_WIDTH]};
      head_s[k]  = mem_r[k][rd_ptr_r[k]];
      empty_s[k] = (count_r[k] == CNT_W'(0));
      full_s[k]  = (count_r[k] == CNT_W'(BUF_DEPTH));
`ifdef CDB_ARB_BYPASS_EN
      bypass_cand_s[k] = empty_s[k] & i_fu_en[k] & ~i_flush;
`else
      bypass_cand_s[k] = 1'b0;
`endif
      cand_s[k] = ~empty_s[k] | bypass_cand_s[k];
      // An empty FIFO can only be a candidate through the bypass path
      if (empty_s[k]) begin
        cand_entry_s[k] = in_entry_s[k];
      end else begin
        cand_entry_s[k] = head_s[k];
      end
    end
  end

  // Round-robin scan from rr: first CDB_PORTS candidates fill slots in order
  always_comb begin
    logic [IDX_W:0]    scan_s;
    logic [IDX_W-1:0]  idx_s;
    logic [SLOT_W-1:0] n_grant_s;
    grant_s    = '0;
    slot_vld_s = '0;
    rr_nxt_s   = rr_r;
    n_grant_s  = '0;
    scan_s     = '0;
    idx_s      = '0;
    for (int j = 0; j < CDB_PORTS; j++) begin
      slot_fu_s[j] = '0;
    end
    for (int off = 0; off < FU_COUNT; off++) begin
      scan_s = {1'b0, rr_r} + (IDX_W+1)'(off);
      if (scan_s >= (IDX_W+1)'(FU_COUNT)) begin
        scan_s = scan_s - (IDX_W+1)'(FU_COUNT);
      end else begin
        scan_s = scan_s;
      end
      idx_s = scan_s[IDX_W-1:0];
      if (cand_s[idx_s] && (n_grant_s < SLOT_W'(CDB_PORTS))) begin
        grant_s[idx_s] = 1'b1;
        for (int j = 0; j < CDB_PORTS; j++) begin
          if (SLOT_W'(j) == n_grant_s) begin
            slot_fu_s[j]  = idx_s;
            slot_vld_s[j] = 1'b1;
          end else begin
            slot_fu_s[j]  = slot_fu_s[j];
          end
        end
        n_grant_s = n_grant_s + SLOT_W'(1);
        // Next scan starts just after the last granted FU
        if (idx_s == IDX_W'(FU_COUNT - 1)) begin
          rr_nxt_s = '0;
        end else begin
          rr_nxt_s = idx_s + IDX_W'(1);
        end
      end else begin
        n_grant_s = n_grant_s;
      end
    end
  end

  // Push/pop decisions and next FIFO occupancy
  always_comb begin
    for (int k = 0; k < FU_COUNT; k++) begin
      pop_s[k]  = grant_s[k] & ~empty_s[k];
      // A granted bypass result never enters the FIFO
      push_s[k] = i_fu_en[k] & ~full_s[k] & ~i_flush & ~(grant_s[k] & empty_s[k]);
      if (i_flush) begin
        count_nxt_s[k] = '0;
      end else begin
        case ({push_s[k], pop_s[k]})
          2'b10:   count_nxt_s[k] = count_r[k] + CNT_W'(1);
          2'b01:   count_nxt_s[k] = count_r[k] - CNT_W'(1);
          default: count_nxt_s[k] = count_r[k];
        endcase
      end
    end
  end

  // Entry selected for each slot
  always_comb begin
    for (int j = 0; j < CDB_PORTS; j++) begin
      slot_entry_s[j] = cand_entry_s[slot_fu_s[j]];
    end
  end

  // Result FIFOs, stall flags and round-robin pointer
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < FU_COUNT; k++) begin
        for (int d = 0; d < BUF_DEPTH; d++) begin
          mem_r[k][d] <= '0;
        end
        rd_ptr_r[k] <= '0;
        wr_ptr_r[k] <= '0;
        count_r[k]  <= '0;
      end
      stall_r <= '0;
      rr_r    <= '0;
    end else if (i_flush) begin
      // Contents are abandoned; pointers restart and rr is kept
      for (int k = 0; k < FU_COUNT; k++) begin
        rd_ptr_r[k] <= '0;
        wr_ptr_r[k] <= '0;
        count_r[k]  <= '0;
      end
      stall_r <= '0;
    end else begin
      for (int k = 0; k < FU_COUNT; k++) begin
        if (push_s[k]) begin
          mem_r[k][wr_ptr_r[k]] <= in_entry_s[k];
          wr_ptr_r[k]           <= wr_ptr_r[k] + PTR_W'(1);
        end
        if (pop_s[k]) begin
          rd_ptr_r[k] <= rd_ptr_r[k] + PTR_W'(1);
        end
        count_r[k] <= count_nxt_s[k];
        stall_r[k] <= (count_nxt_s[k] == CNT_W'(BUF_DEPTH));
      end
      rr_r <= rr_nxt_s;
    end
  end

  // CDB output registers; ungranted slots drop valid and keep their fields
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_cdb_en       <= '0;
      o_cdb_redirect <= '0;
      o_cdb_data     <= '0;
      o_cdb_addr     <= '0;
      o_cdb_tag      <= '0;
    end else begin
      for (int j = 0; j < CDB_PORTS; j++) begin
        if (slot_vld_s[j] && !i_flush) begin
          o_cdb_en[j]                              <= 1'b1;
          o_cdb_redirect[j]                        <= slot_entry_s[j][RED_BIT];
          o_cdb_data[j*DATA_WIDTH +: DATA_WIDTH]   <= slot_entry_s[j][DATA_LSB +: DATA_WIDTH];
          o_cdb_addr[j*ADDR_WIDTH +: ADDR_WIDTH]   <= slot_entry_s[j][ADDR_LSB +: ADDR_WIDTH];
          o_cdb_tag[j*TAG_WIDTH +: TAG_WIDTH]      <= slot_entry_s[j][TAG_LSB +: TAG_WIDTH];
        end else begin
          o_cdb_en[j] <= 1'b0;
        end
      end
    end
  end

  cdb_arbiter_chk #(
    .FU_COUNT (FU_COUNT)
  ) u_chk (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_flush    (i_flush),
    .i_fu_en    (i_fu_en),
    .o_fu_stall (stall_r)
  );

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed vector table on a 4-FU / 2-slot
// instance, hand sequences for reset, bypass latency, and a scoreboarded
// backpressure run on a 4-FU / 1-slot instance.
module tb_cdb_arbiter;

`ifdef CDB_ARB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic n_rst;

  // Instance A: FU_COUNT 4, CDB_PORTS 2
  logic         a_flush;
  logic [3:0]   a_en, a_redir;
  logic [127:0] a_data, a_addr;
  logic [23:0]  a_tag;
  logic [3:0]   a_stall;
  logic [1:0]   a_cdb_en, a_cdb_redir;
  logic [63:0]  a_cdb_data, a_cdb_addr;
  logic [11:0]  a_cdb_tag;

  // Instance B: FU_COUNT 4, CDB_PORTS 1
  logic         b_flush;
  logic [3:0]   b_en, b_redir;
  logic [127:0] b_data, b_addr;
  logic [23:0]  b_tag;
  logic [3:0]   b_stall;
  logic [0:0]   b_cdb_en, b_cdb_redir;
  logic [31:0]  b_cdb_data, b_cdb_addr;
  logic [5:0]   b_cdb_tag;

  cdb_arbiter #(.FU_COUNT(4), .CDB_PORTS(2), .BUF_DEPTH(2),
                .DATA_WIDTH(32), .ADDR_WIDTH(32), .TAG_WIDTH(6)) dut_a (
    .clk(clk), .n_rst(n_rst), .i_flush(a_flush), .i_fu_en(a_en),
    .i_fu_redirect(a_redir), .i_fu_data(a_data), .i_fu_addr(a_addr),
    .i_fu_tag(a_tag), .o_fu_stall(a_stall), .o_cdb_en(a_cdb_en),
    .o_cdb_redirect(a_cdb_redir), .o_cdb_data(a_cdb_data),
    .o_cdb_addr(a_cdb_addr), .o_cdb_tag(a_cdb_tag));

  cdb_arbiter #(.FU_COUNT(4), .CDB_PORTS(1), .BUF_DEPTH(2),
                .DATA_WIDTH(32), .ADDR_WIDTH(32), .TAG_WIDTH(6)) dut_b (
    .clk(clk), .n_rst(n_rst), .i_flush(b_flush), .i_fu_en(b_en),
    .i_fu_redirect(b_redir), .i_fu_data(b_data), .i_fu_addr(b_addr),
    .i_fu_tag(b_tag), .o_fu_stall(b_stall), .o_cdb_en(b_cdb_en),
    .o_cdb_redirect(b_cdb_redir), .o_cdb_data(b_cdb_data),
    .o_cdb_addr(b_cdb_addr), .o_cdb_tag(b_cdb_tag));

  int checks = 0;
  int errors = 0;
  int cur_row = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got %0h, expected %0h", name, cur_row, act, exp);
    end
  endtask

  function automatic logic [31:0] fdata(input logic [5:0] t);
    return 32'hC0DE_0000 | {26'd0, t};
  endfunction

  function automatic logic [31:0] faddr(input logic [5:0] t);
    return 32'hADD0_0000 | {26'd0, t};
  endfunction

  function automatic logic [23:0] tags_c(input int c);
    return {6'(30 + c), 6'(20 + c), 6'(10 + c), 6'(c)};
  endfunction

  task automatic drive_a(input logic [3:0] en, input logic flush,
                         input logic [23:0] tags, input logic dead);
    logic [5:0] t;
    a_en    = en;
    a_flush = flush;
    for (int k = 0; k < 4; k++) begin
      t = tags[k*6 +: 6];
      a_tag[k*6 +: 6]    = t;
      a_data[k*32 +: 32] = fdata(t);
      a_addr[k*32 +: 32] = faddr(t);
      a_redir[k]         = t[1];
    end
    if (dead) a_data[63:32] = 32'hDEADBEEF;
  endtask

  task automatic drive_idle();
    drive_a(4'b0000, 1'b0, 24'd0, 1'b0);
    b_en = 4'b0; b_flush = 1'b0; b_redir = 4'b0;
    b_data = '0; b_addr = '0; b_tag = '0;
  endtask

  // Async reset pulse placed between clock edges
  task automatic do_reset();
    drive_idle();
    n_rst = 1'b0;
    #2;
    n_rst = 1'b1;
    #1;
  endtask

  typedef struct packed {
    logic        rst;
    logic        flush;
    logic [3:0]  en;
    logic        dead;
    logic [23:0] tags;
    logic [1:0]  x_en;
    logic [5:0]  x_t0;
    logic [5:0]  x_t1;
    logic [31:0] x_d0;
    logic [3:0]  x_stall;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic flush, input logic [3:0] en,
                              input logic [23:0] tags, input logic [1:0] x_en,
                              input logic [5:0] x_t0, input logic [5:0] x_t1,
                              input logic [3:0] x_stall);
    vec_t v;
    v.rst = rst; v.flush = flush; v.en = en; v.dead = 1'b0; v.tags = tags;
    v.x_en = x_en; v.x_t0 = x_t0; v.x_t1 = x_t1; v.x_d0 = fdata(x_t0);
    v.x_stall = x_stall;
    return v;
  endfunction

  vec_t vt [23];

  typedef struct {
    int          fu;
    logic [31:0] d;
    logic [5:0]  t;
    int          pc;
  } sb_t;
  sb_t sb [$];

  initial begin
    int   seq [4];
    int   fu2_issued, fu2_seen, prev_vis, c, found, fu, head;
    logic stall2_seen, done;
    logic [1:0] exp_c1, exp_c2;

    n_rst = 1'b0;
    drive_idle();
    @(posedge clk); #1;
    chk("reset_cdb_en", 64'(a_cdb_en), 64'd0);
    chk("reset_stall", 64'(a_stall), 64'd0);
    chk("reset_tag", 64'(a_cdb_tag), 64'd0);
    n_rst = 1'b1;
    @(posedge clk); #1;

`ifndef CDB_ARB_BYPASS_EN
    // Single producer, then rr check (rr = 2 after FU1)
    vt[0]  = mk(1, 0, 4'b0010, {6'd0, 6'd0, 6'd5, 6'd0}, 2'b00, 0, 0, 4'b0000);
    vt[0].dead = 1'b1;
    vt[1]  = mk(0, 0, 4'b0000, 24'd0, 2'b01, 6'd5, 0, 4'b0000);
    vt[1].x_d0 = 32'hDEADBEEF;
    vt[2]  = mk(0, 0, 4'b0000, 24'd0, 2'b00, 0, 0, 4'b0000);
    vt[3]  = mk(0, 0, 4'b0111, {6'd0, 6'd3, 6'd2, 6'd1}, 2'b00, 0, 0, 4'b0000);
    vt[4]  = mk(0, 0, 4'b0000, 24'd0, 2'b11, 6'd3, 6'd1, 4'b0000);
    vt[5]  = mk(0, 0, 4'b0000, 24'd0, 2'b01, 6'd2, 0, 4'b0000);
    vt[6]  = mk(0, 0, 4'b0000, 24'd0, 2'b00, 0, 0, 4'b0000);
    // Contention from rr = 0, then rr = 0 check
    vt[7]  = mk(1, 0, 4'b1111, {6'd13, 6'd12, 6'd11, 6'd10}, 2'b00, 0, 0, 4'b0000);
    vt[8]  = mk(0, 0, 4'b0000, 24'd0, 2'b11, 6'd10, 6'd11, 4'b0000);
    vt[9]  = mk(0, 0, 4'b0000, 24'd0, 2'b11, 6'd12, 6'd13, 4'b0000);
    vt[10] = mk(0, 0, 4'b0000, 24'd0, 2'b00, 0, 0, 4'b0000);
    vt[11] = mk(0, 0, 4'b1001, {6'd30, 6'd0, 6'd0, 6'd31}, 2'b00, 0, 0, 4'b0000);
    vt[12] = mk(0, 0, 4'b0000, 24'd0, 2'b11, 6'd31, 6'd30, 4'b0000);
    vt[13] = mk(0, 0, 4'b0000, 24'd0, 2'b00, 0, 0, 4'b0000);
    // Fill, flush at cycle 5 with FU0 en, post-flush result
    vt[14] = mk(1, 0, 4'b1111, tags_c(0), 2'b00, 0, 0, 4'b0000);
    vt[15] = mk(0, 0, 4'b1111, tags_c(1), 2'b11, 6'd0, 6'd10, 4'b1100);
    vt[16] = mk(0, 0, 4'b0011, tags_c(2), 2'b11, 6'd20, 6'd30, 4'b0011);
    vt[17] = mk(0, 0, 4'b1100, tags_c(3), 2'b11, 6'd1, 6'd11, 4'b1100);
    vt[18] = mk(0, 0, 4'b0011, tags_c(4), 2'b11, 6'd21, 6'd31, 4'b0011);
    vt[19] = mk(0, 1, 4'b0001, tags_c(5), 2'b00, 0, 0, 4'b0000);
    vt[20] = mk(0, 0, 4'b0100, tags_c(6), 2'b00, 0, 0, 4'b0000);
    vt[21] = mk(0, 0, 4'b0000, 24'd0, 2'b01, 6'd26, 0, 4'b0000);
    vt[22] = mk(0, 0, 4'b0000, 24'd0, 2'b00, 0, 0, 4'b0000);

    for (int i = 0; i < 23; i++) begin
      cur_row = i;
      if (vt[i].rst) do_reset();
      drive_a(vt[i].en, vt[i].flush, vt[i].tags, vt[i].dead);
      @(posedge clk); #1;
      chk("cdb_en", 64'(a_cdb_en), 64'(vt[i].x_en));
      chk("fu_stall", 64'(a_stall), 64'(vt[i].x_stall));
      if (vt[i].x_en[0]) begin
        chk("slot0_tag", 64'(a_cdb_tag[5:0]), 64'(vt[i].x_t0));
        chk("slot0_data", 64'(a_cdb_data[31:0]), 64'(vt[i].x_d0));
        chk("slot0_addr", 64'(a_cdb_addr[31:0]), 64'(faddr(vt[i].x_t0)));
        chk("slot0_redir", 64'(a_cdb_redir[0]), 64'(vt[i].x_t0[1]));
      end
      if (vt[i].x_en[1]) begin
        chk("slot1_tag", 64'(a_cdb_tag[11:6]), 64'(vt[i].x_t1));
        chk("slot1_data", 64'(a_cdb_data[63:32]), 64'(fdata(vt[i].x_t1)));
      end
    end
    drive_idle();
`endif

    // Async reset in the middle of a two-slot broadcast
    cur_row = 100;
    do_reset();
    drive_a(4'b1111, 1'b0, {6'd13, 6'd12, 6'd11, 6'd10}, 1'b0);
    @(posedge clk); #1;
    drive_a(4'b1111, 1'b0, {6'd23, 6'd22, 6'd21, 6'd20}, 1'b0);
    @(posedge clk); #1;
    drive_idle();
    chk("pre_reset_en", 64'(a_cdb_en), 64'h3);
    #2;
    n_rst = 1'b0;
    #1;
    chk("async_rst_en", 64'(a_cdb_en), 64'd0);
    chk("async_rst_stall", 64'(a_stall), 64'd0);
    chk("async_rst_data", a_cdb_data, 64'd0);
    chk("async_rst_addr", a_cdb_addr, 64'd0);
    chk("async_rst_tag", 64'(a_cdb_tag), 64'd0);
    chk("async_rst_redir", 64'(a_cdb_redir), 64'd0);
    #1;
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_empty", 64'(a_cdb_en), 64'd0);
    end
    drive_a(4'b1001, 1'b0, {6'd30, 6'd0, 6'd0, 6'd31}, 1'b0);
    @(posedge clk); #1;
    drive_idle();
    if (LAT == 2) begin
      @(posedge clk); #1;
    end
    chk("post_rst_rr_en", 64'(a_cdb_en), 64'h3);
    chk("post_rst_rr_t0", 64'(a_cdb_tag[5:0]), 64'd31);
    chk("post_rst_rr_t1", 64'(a_cdb_tag[11:6]), 64'd30);

    // Idle FU3 result latency
    cur_row = 200;
    do_reset();
`ifdef CDB_ARB_BYPASS_EN
    exp_c1 = 2'b01; exp_c2 = 2'b00;
`else
    exp_c1 = 2'b00; exp_c2 = 2'b01;
`endif
    drive_a(4'b1000, 1'b0, {6'd7, 6'd0, 6'd0, 6'd0}, 1'b0);
    @(posedge clk); #1;
    drive_idle();
    chk("lat_cycle1_en", 64'(a_cdb_en), 64'(exp_c1));
    @(posedge clk); #1;
    chk("lat_cycle2_en", 64'(a_cdb_en), 64'(exp_c2));
    chk("lat_tag", 64'(a_cdb_tag[5:0]), 64'd7);
    chk("lat_data", 64'(a_cdb_data[31:0]), 64'(fdata(6'd7)));

    // Backpressure on the single-slot instance
    cur_row = 300;
    do_reset();
    for (int k = 0; k < 4; k++) seq[k] = 0;
    fu2_issued = 0; fu2_seen = 0; prev_vis = -100; stall2_seen = 1'b0;
    c = 0; done = 1'b0;
    while (!done && c < 300) begin
      if (b_stall[2]) stall2_seen = 1'b1;
      if (b_cdb_en[0]) begin
        fu = int'(b_cdb_data[31:28]);
        found = -1;
        for (int i = 0; i < sb.size(); i++) begin
          if (found < 0 && sb[i].fu == fu) found = i;
        end
        if (found < 0) begin
          checks++; errors++;
          $display("FAIL bp_unexpected: got data %0h tag %0h, expected no broadcast", b_cdb_data, b_cdb_tag);
        end else begin
          chk("bp_data", 64'(b_cdb_data), 64'(sb[found].d));
          chk("bp_tag", 64'(b_cdb_tag), 64'(sb[found].t));
          if (fu == 2) begin
            head = (sb[found].pc + 1 > prev_vis) ? sb[found].pc + 1 : prev_vis;
            chk("bp_fu2_wait", 64'((c - head) <= 4), 64'd1);
            prev_vis = c;
            fu2_seen++;
          end
          sb.delete(found);
        end
      end
      for (int k = 0; k < 4; k++) begin
        logic want;
        want = (k == 2) ? (fu2_issued < 3) : (c < 30);
        b_en[k] = want & ~b_stall[k];
        b_redir[k] = 1'b0;
        b_data[k*32 +: 32] = {4'(k), 12'h000, 16'(seq[k])};
        b_addr[k*32 +: 32] = {4'(k), 12'h000, 16'(seq[k])};
        b_tag[k*6 +: 6] = (k == 2) ? 6'(20 + fu2_issued) : 6'(seq[k]);
        if (b_en[k]) begin
          sb.push_back('{fu: k, d: b_data[k*32 +: 32], t: b_tag[k*6 +: 6], pc: c});
          seq[k]++;
          if (k == 2) fu2_issued++;
        end
      end
      @(posedge clk); #1;
      c++;
      done = (c >= 30) && (fu2_issued == 3) && (sb.size() == 0);
    end
    b_en = 4'b0;
    chk("bp_lost", 64'(sb.size()), 64'd0);
    chk("bp_fu2_count", 64'(fu2_seen), 64'd3);
    chk("bp_stall2_seen", 64'(stall2_seen), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_no_dup", 64'(b_cdb_en), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
